// File: rtl/nf_debug_pkg.sv
// Shared definitions for the debug snapshot block: FSM states and parameter defaults.
package nf_debug_pkg;

  localparam int unsigned NF_PORT_W_DEF = 96;
  localparam int unsigned NF_CNT_W_DEF  = 16;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_HOLD    = 2'd2
  } snap_state_e;

endpackage : nf_debug_pkg

// File: rtl/nf_debug_port_monitor.sv
// Per-port activity monitor: two-stage status pipeline, sticky toggle flags
// and a saturating change counter.
//   clk, reset  : clock, synchronous active-high reset
//   status_in   : live status word for this port
//   clr_req     : clear sticky bits and counter (a toggle in the same cycle wins)
//   live_q      : first pipeline stage of the status word
//   sticky      : per-bit "has toggled" flags
//   count       : number of cycles in which any bit toggled, saturating
module nf_debug_port_monitor
  import nf_debug_pkg::*;
#(
  parameter int unsigned PORT_W = NF_PORT_W_DEF,
  parameter int unsigned CNT_W  = NF_CNT_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [PORT_W-1:0] status_in,
  input  logic              clr_req,
  output logic [PORT_W-1:0] live_q,
  output logic [PORT_W-1:0] sticky,
  output logic [CNT_W-1:0]  count
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [PORT_W-1:0] live_qq;
  logic [PORT_W-1:0] toggle_c;
  logic              changed_c;

  assign toggle_c  = live_q ^ live_qq;
  assign changed_c = |toggle_c;

  // Clear drops history but still records the current cycle's toggle.
  always_ff @(posedge clk) begin
    if (reset) begin
      live_q  <= '0;
      live_qq <= '0;
      sticky  <= '0;
      count   <= '0;
    end else begin
      live_q  <= status_in;
      live_qq <= live_q;
      if (clr_req) begin
        sticky <= toggle_c;
        count  <= changed_c ? CNT_W'(1) : '0;
      end else begin
        sticky <= sticky | toggle_c;
        if (changed_c && (count != CNT_MAX)) begin
          count <= count + CNT_W'(1);
        end
      end
    end
  end

endmodule : nf_debug_port_monitor

// File: rtl/nf_debug_snapshot.sv
// Debug snapshot of per-port status activity. Monitors run continuously; a
// snap_req freezes live status, sticky flags and counters into the snap_*
// registers, which stay valid until snap_ack.
//   clk, reset  : clock, synchronous active-high reset
//   status_in   : packed live status, port p at [(p+1)*PORT_W-1 : p*PORT_W]
//   snap_req    : request a snapshot (accepted only when idle)
//   snap_ack    : consumer finished reading (honoured only while holding)
//   clr_req     : clear live sticky flags and counters
//   snap_status : frozen status words
//   snap_sticky : frozen sticky flags
//   snap_count  : frozen counters, packed per port
//   snap_valid  : snapshot outputs are stable
//   busy        : snapshot machine not idle
module nf_debug_snapshot
  import nf_debug_pkg::*;
#(
  parameter int unsigned NUM_PORTS = 4,
  parameter int unsigned PORT_W    = NF_PORT_W_DEF,
  parameter int unsigned CNT_W     = NF_CNT_W_DEF
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_PORTS*PORT_W-1:0] status_in,
  input  logic                       snap_req,
  input  logic                       snap_ack,
  input  logic                       clr_req,
  output logic [NUM_PORTS*PORT_W-1:0] snap_status,
  output logic [NUM_PORTS*PORT_W-1:0] snap_sticky,
  output logic [NUM_PORTS*CNT_W-1:0]  snap_count,
  output logic                       snap_valid,
  output logic                       busy
);

  localparam int unsigned STAT_W = NUM_PORTS * PORT_W;
  localparam int unsigned CNTS_W = NUM_PORTS * CNT_W;

  logic [STAT_W-1:0] live_all;
  logic [STAT_W-1:0] sticky_all;
  logic [CNTS_W-1:0] count_all;

  snap_state_e state_q;
  snap_state_e state_next_c;

  // One independent monitor per port.
  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    nf_debug_port_monitor #(
      .PORT_W (PORT_W),
      .CNT_W  (CNT_W)
    ) u_mon (
      .clk       (clk),
      .reset     (reset),
      .status_in (status_in[p*PORT_W +: PORT_W]),
      .clr_req   (clr_req),
      .live_q    (live_all[p*PORT_W +: PORT_W]),
      .sticky    (sticky_all[p*PORT_W +: PORT_W]),
      .count     (count_all[p*CNT_W +: CNT_W])
    );
  end

  // Next-state logic.
  always_comb begin
    state_next_c = state_q;
    case (state_q)
      ST_IDLE:    if (snap_req) state_next_c = ST_CAPTURE;
      ST_CAPTURE: state_next_c = ST_HOLD;
      ST_HOLD:    if (snap_ack) state_next_c = ST_IDLE;
      default:    state_next_c = ST_IDLE;
    endcase
  end

  // State, registered flags and snapshot registers. The snapshot loads the
  // monitor values present during CAPTURE, so a concurrent clear is not seen.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      snap_valid  <= 1'b0;
      busy        <= 1'b0;
      snap_status <= '0;
      snap_sticky <= '0;
      snap_count  <= '0;
    end else begin
      state_q    <= state_next_c;
      snap_valid <= (state_next_c == ST_HOLD);
      busy       <= (state_next_c != ST_IDLE);
      if (state_q == ST_CAPTURE) begin
        snap_status <= live_all;
        snap_sticky <= sticky_all;
        snap_count  <= count_all;
      end
    end
  end

endmodule : nf_debug_snapshot

// File: tb/tb_nf_debug_snapshot.sv
// Bench for nf_debug_snapshot: directed scenarios plus randomized traffic,
// all checked against a cycle-level behavioural model.
module tb_nf_debug_snapshot;

  localparam int NP = 4;
  localparam int PW = 96;
  localparam int CW = 16;
  localparam int SW = NP * PW;
  localparam int CSW = NP * CW;
  localparam int CMAX = (1 << CW) - 1;

  logic           clk = 1'b0;
  logic           reset;
  logic [SW-1:0]  status_in;
  logic           snap_req;
  logic           snap_ack;
  logic           clr_req;
  logic [SW-1:0]  snap_status;
  logic [SW-1:0]  snap_sticky;
  logic [CSW-1:0] snap_count;
  logic           snap_valid;
  logic           busy;

  int n_vec = 0;
  int n_err = 0;

  // Behavioural model: last two sampled words, sticky flags, counters,
  // snapshot copies and whether a capture/hold is in progress.
  logic [PW-1:0] m_h1[NP];
  logic [PW-1:0] m_h2[NP];
  logic [PW-1:0] m_sticky[NP];
  int            m_count[NP];
  logic [PW-1:0] m_snap_status[NP];
  logic [PW-1:0] m_snap_sticky[NP];
  int            m_snap_count[NP];
  bit            m_capturing;
  bit            m_holding;

  logic [SW-1:0] cur;

  always #5 clk = ~clk;

  nf_debug_snapshot #(
    .NUM_PORTS (NP),
    .PORT_W    (PW),
    .CNT_W     (CW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .status_in   (status_in),
    .snap_req    (snap_req),
    .snap_ack    (snap_ack),
    .clr_req     (clr_req),
    .snap_status (snap_status),
    .snap_sticky (snap_sticky),
    .snap_count  (snap_count),
    .snap_valid  (snap_valid),
    .busy        (busy)
  );

  task automatic chk(input string tag, input logic [SW-1:0] obs, input logic [SW-1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge(input logic [SW-1:0] st, input logic sr, input logic sa,
                            input logic cl, input logic rs);
    logic [PW-1:0] tog;
    if (rs) begin
      for (int p = 0; p < NP; p++) begin
        m_h1[p] = '0; m_h2[p] = '0; m_sticky[p] = '0; m_count[p] = 0;
        m_snap_status[p] = '0; m_snap_sticky[p] = '0; m_snap_count[p] = 0;
      end
      m_capturing = 0;
      m_holding = 0;
    end else begin
      if (m_capturing) begin
        for (int p = 0; p < NP; p++) begin
          m_snap_status[p] = m_h1[p];
          m_snap_sticky[p] = m_sticky[p];
          m_snap_count[p]  = m_count[p];
        end
      end
      for (int p = 0; p < NP; p++) begin
        tog = m_h1[p] ^ m_h2[p];
        if (cl) begin
          m_sticky[p] = tog;
          m_count[p]  = (tog != '0) ? 1 : 0;
        end else begin
          m_sticky[p] = m_sticky[p] | tog;
          if (tog != '0 && m_count[p] < CMAX) m_count[p] = m_count[p] + 1;
        end
        m_h2[p] = m_h1[p];
        m_h1[p] = st[p*PW +: PW];
      end
      if (m_holding) begin
        if (sa) m_holding = 0;
      end else if (m_capturing) begin
        m_capturing = 0;
        m_holding = 1;
      end else if (sr) begin
        m_capturing = 1;
      end
    end
  endtask

  task automatic check_model();
    logic [SW-1:0]  e_stat;
    logic [SW-1:0]  e_stk;
    logic [CSW-1:0] e_cnt;
    for (int p = 0; p < NP; p++) begin
      e_stat[p*PW +: PW] = m_snap_status[p];
      e_stk[p*PW +: PW]  = m_snap_sticky[p];
      e_cnt[p*CW +: CW]  = CW'(m_snap_count[p]);
    end
    chk("snap_valid", SW'(snap_valid), SW'(m_holding));
    chk("busy", SW'(busy), SW'(m_holding | m_capturing));
    chk("snap_status", snap_status, e_stat);
    chk("snap_sticky", snap_sticky, e_stk);
    chk("snap_count", SW'(snap_count), SW'(e_cnt));
  endtask

  task automatic tick(input logic [SW-1:0] st, input logic sr, input logic sa,
                      input logic cl, input logic rs);
    status_in = st;
    snap_req  = sr;
    snap_ack  = sa;
    clr_req   = cl;
    reset     = rs;
    @(posedge clk);
    model_edge(st, sr, sa, cl, rs);
    #1;
    check_model();
  endtask

  initial begin
    logic [SW-1:0]  e;
    logic [CSW-1:0] ec;
    int             bitpos;

    cur = '0;
    status_in = '0; snap_req = 0; snap_ack = 0; clr_req = 0; reset = 1;

    // Reset with garbage on the inputs; everything must read zero.
    tick({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom,
          $urandom, $urandom, $urandom, $urandom, $urandom, $urandom}, 1, 1, 1, 1);
    tick(cur, 1, 0, 1, 1);
    chk("reset_status", snap_status, '0);
    chk("reset_busy", SW'({busy, snap_valid}), '0);

    // Port 2 bit 5 pulses 0->1->0: two toggles.
    tick(cur, 0, 0, 0, 0);
    cur[2*PW+5] = 1'b1;
    tick(cur, 0, 0, 0, 0);
    cur[2*PW+5] = 1'b0;
    tick(cur, 0, 0, 0, 0);
    tick(cur, 0, 0, 0, 0);
    tick(cur, 0, 0, 0, 0);
    tick(cur, 1, 0, 0, 0);
    chk("lat_busy_n1", SW'({busy, snap_valid}), SW'(2'b10));
    tick(cur, 0, 0, 0, 0);
    chk("lat_valid_n2", SW'(snap_valid), SW'(1));
    e = '0; e[2*PW+5] = 1'b1;
    chk("p2_sticky", snap_sticky, e);
    ec = '0; ec[2*CW +: CW] = CW'(2);
    chk("p2_count", SW'(snap_count), SW'(ec));
    tick(cur, 1, 0, 0, 0);
    chk("req_in_hold_ignored", SW'({busy, snap_valid}), SW'(2'b11));
    tick(cur, 0, 1, 0, 0);
    chk("ack_idle", SW'({busy, snap_valid}), '0);
    chk("ack_keeps_sticky", snap_sticky, e);
    chk("ack_keeps_count", SW'(snap_count), SW'(ec));

    // Clear coinciding with a port 1 toggle: set wins.
    cur[1*PW] = 1'b1;
    tick(cur, 0, 0, 0, 0);
    tick(cur, 0, 0, 1, 0);
    tick(cur, 0, 0, 0, 0);
    tick(cur, 1, 0, 0, 0);
    tick(cur, 0, 0, 0, 0);
    e = '0; e[1*PW] = 1'b1;
    chk("clr_set_sticky", snap_sticky, e);
    ec = '0; ec[1*CW +: CW] = CW'(1);
    chk("clr_set_count", SW'(snap_count), SW'(ec));
    tick(cur, 0, 1, 0, 0);

    // Port 3 changes 7 times, then clear during CAPTURE.
    for (int i = 0; i < 7; i++) begin
      cur[3*PW+12] = (i % 2 == 0);
      tick(cur, 0, 0, 0, 0);
    end
    tick(cur, 0, 0, 0, 0);
    tick(cur, 0, 0, 0, 0);
    tick(cur, 0, 0, 0, 0);
    tick(cur, 1, 0, 0, 0);
    tick(cur, 0, 0, 1, 0);
    ec = '0; ec[3*CW +: CW] = CW'(7); ec[1*CW +: CW] = CW'(1);
    chk("capture_preclear_count", SW'(snap_count), SW'(ec));
    tick(cur, 0, 1, 0, 0);
    tick(cur, 1, 0, 0, 0);
    tick(cur, 0, 0, 0, 0);
    chk("postclear_count", SW'(snap_count), '0);
    tick(cur, 0, 1, 0, 0);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 1) == 0) begin
        bitpos = int'($urandom_range(0, SW - 1));
        cur[bitpos] = ~cur[bitpos];
      end
      if ($urandom_range(0, 15) == 0) begin
        for (int w = 0; w < SW / 32; w++) cur[w*32 +: 32] = $urandom;
      end
      tick(cur, ($urandom_range(0, 5) == 0), ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 19) == 0), ($urandom_range(0, 63) == 0));
    end

    // Saturation: port 0 toggles every cycle for 70000 cycles.
    cur = '0;
    tick(cur, 0, 0, 0, 1);
    for (int i = 0; i < 70000; i++) begin
      cur[0] = ~cur[0];
      tick(cur, 0, 0, 0, 0);
    end
    tick(cur, 1, 0, 0, 0);
    tick(cur, 0, 0, 0, 0);
    chk("sat_count_p0", SW'(snap_count[CW-1:0]), SW'(CMAX));

    // Reset in HOLD abandons the snapshot and beats every other request.
    tick(cur, 1, 1, 1, 1);
    chk("rst_hold_flags", SW'({busy, snap_valid}), '0);
    chk("rst_hold_status", snap_status, '0);
    chk("rst_hold_sticky", snap_sticky, '0);
    chk("rst_hold_count", SW'(snap_count), '0);
    tick(cur, 0, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_nf_debug_snapshot

// File: doc/nf_debug_snapshot.md
NF_DEBUG_SNAPSHOT -- requirements
Module: nf_debug_snapshot

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 4, number of monitored Ethernet ports, legal range 1..8.
REQ-002 SHALL have parameter PORT_W, default 96, width of one port's packed status word.
REQ-003 SHALL have parameter CNT_W, default 16, width of each per-port change counter.
REQ-004 SHALL have port clk  in  1  single clock for all logic.
REQ-005 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-006 SHALL have port status_in  in  NUM_PORTS*PORT_W  live packed status; port p occupies bits [(p+1)*PORT_W-1 : p*PORT_W].
REQ-007 SHALL have port snap_req  in  1  single-cycle request to take a snapshot.
REQ-008 SHALL have port snap_ack  in  1  consumer has read the snapshot.
REQ-009 SHALL have port clr_req  in  1  single-cycle request to clear sticky bits and counters.
REQ-010 SHALL have port snap_status  out  NUM_PORTS*PORT_W  frozen status word.
REQ-011 SHALL have port snap_sticky  out  NUM_PORTS*PORT_W  frozen per-bit toggle flags.
REQ-012 SHALL have port snap_count  out  NUM_PORTS*CNT_W  frozen per-port change counts, same port packing as status_in.
REQ-013 SHALL have port snap_valid  out  1  snapshot outputs are stable and readable.
REQ-014 SHALL have port busy  out  1  FSM is not in IDLE.

Function
REQ-015 SHALL register status_in into live_q and live_q into live_qq, one cycle each.
REQ-016 SHALL define toggle = live_q XOR live_qq, evaluated bitwise per port.
REQ-017 SHALL set each sticky bit in a cycle where its toggle bit is 1, and hold it otherwise.
REQ-018 SHALL increment a port's counter by 1 in each cycle where that port's toggle word is non-zero.
REQ-019 SHALL saturate each counter at 2^CNT_W-1, with no wrap-around.
REQ-020 On clr_req SHALL zero all sticky bits and counters on the next edge.
REQ-021 When clr_req coincides with a toggle, set SHALL win: the sticky bit ends at 1 and the counter ends at 1.
REQ-022 SHALL implement an FSM with states IDLE, CAPTURE and HOLD.
REQ-023 FSM transitions SHALL be: IDLE->CAPTURE on snap_req; CAPTURE->HOLD unconditionally; HOLD->IDLE on snap_ack.
REQ-024 At the CAPTURE-ending edge, the snap_* registers SHALL load the live_q, sticky and counter values present during CAPTURE.
REQ-025 SHALL assert snap_valid exactly while in HOLD; snap_req issued in the same cycle as snap_req being accepted gives latency 2 cycles from snap_req to snap_valid.
REQ-026 snap_req SHALL be ignored while in CAPTURE or HOLD.
REQ-027 snap_ack SHALL be ignored outside HOLD.
REQ-028 snap_* outputs SHALL hold their values from HOLD until the next CAPTURE, including while in IDLE.
REQ-029 clr_req in CAPTURE SHALL NOT affect the snapshot, which captures pre-clear values; the clear applies to live state only.
REQ-030 Monitoring (REQ-015..021) SHALL continue in every FSM state.

Reset
REQ-031 reset SHALL clear live_q, live_qq, sticky bits, counters and all snap_* outputs to 0.
REQ-032 reset SHALL force the FSM to IDLE and drive snap_valid=0 and busy=0.
REQ-033 reset asserted mid-HOLD SHALL abandon the snapshot with no snap_ack required.
REQ-034 reset SHALL take priority over snap_req, clr_req and snap_ack.
REQ-035 The first cycle after reset SHALL NOT count a toggle; live_q and live_qq are both 0.

Structure
REQ-036 Package nf_debug_pkg SHALL hold the FSM state enumeration and the defaults for PORT_W and CNT_W.
REQ-037 Sub-module nf_debug_port_monitor SHALL hold one port's live_q, live_qq, sticky and counter, instantiated NUM_PORTS times via generate.
REQ-038 The FSM and snapshot registers SHALL reside in the top level.

Verification
REQ-039 Port 2 bit 5 toggles 0->1->0 over 3 cycles, then snapshot -> snap_sticky port2 bit5=1, snap_count port2=2, all other ports 0.
REQ-040 Port 0 toggles every cycle for 70000 cycles with CNT_W=16 -> snap_count port0=65535.
REQ-041 clr_req in the same cycle as a port-1 toggle -> after the edge, sticky bit=1 and counter=1.
REQ-042 snap_req at cycle n -> busy at n+1, snap_valid at n+2; second snap_req during HOLD -> ignored; snap_ack -> IDLE next cycle with snap_* unchanged.
REQ-043 clr_req during CAPTURE -> snapshot shows pre-clear counts (e.g. 7), live counter 0 afterwards.
REQ-044 reset during HOLD -> snap_valid=0, all snap_*=0, FSM in IDLE next cycle.
